// File: rtl/pc_pkg.sv
// Shared types and default widths for the program-counter unit and its decode partner.
// The op encoding is fixed: decode drives these 3-bit values directly.
package pc_pkg;

    typedef enum logic [2:0] {
        NEXT = 3'd0,
        JMP  = 3'd1,
        BEQZ = 3'd2,
        BNEZ = 3'd3,
        BREL = 3'd4,
        CALL = 3'd5,
        RET  = 3'd6,
        HOLD = 3'd7
    } pc_op_t;

    localparam int PC_W_DEF       = 10;
    localparam int TGT_W_DEF      = 16;
    localparam int OFF_W_DEF      = 8;
    localparam int STACK_D_DEF    = 4;
    localparam int START_ADDR_DEF = 0;
    localparam int HALT_ADDR_DEF  = 63;

    // Branch condition for the conditional ops; unconditional ops report taken.
    function automatic logic cond_taken(input pc_op_t op, input logic zero);
        logic taken;
        taken = 1'b1;
        case (op)
            BEQZ:    taken = zero;
            BNEZ:    taken = !zero;
            BREL:    taken = zero;
            default: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a small LIFO with depth tracking.
// Push when full and pop when empty are ignored; the caller flags those cases.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_data,
    output logic [W-1:0]                 o_top,
    output logic [$clog2(DEPTH+1)-1:0]   o_depth,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [DW-1:0] r_depth;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_depth == DW'(DEPTH));
    assign o_empty   = (r_depth == '0);
    assign o_depth   = r_depth;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty && !i_push;

    assign w_wr_idx  = IW'(r_depth);
    assign w_top_idx = o_empty ? '0 : IW'(r_depth - 1'b1);
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= '0;
        end else if (w_do_push) begin
            r_depth <= r_depth + 1'b1;
        end else if (w_do_pop) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    // Entries are not reset: depth alone defines which ones are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with jumps, conditional/relative branches and halt-address freeze.
// Define PC_RAS_EN to add call/return through a return-address stack; otherwise CALL=JMP, RET=NEXT.
module pc_unit
    import pc_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int TGT_W      = TGT_W_DEF,
    parameter int OFF_W      = OFF_W_DEF,
    parameter int STACK_D    = STACK_D_DEF,
    parameter int START_ADDR = START_ADDR_DEF,
    parameter int HALT_ADDR  = HALT_ADDR_DEF
) (
    input  logic                           CLK,
    input  logic                           init_n,
    input  logic                           halt_req,
    input  logic [2:0]                     op,
    input  logic                           ALU_zero,
    input  logic [TGT_W-1:0]               Target,
    input  logic [OFF_W-1:0]               Offset,
    output logic [PC_W-1:0]                PC,
    output logic                           done,
    output logic [$clog2(STACK_D+1)-1:0]   ras_depth,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_inc;
    logic [PC_W-1:0] w_tgt;
    logic [PC_W-1:0] w_rel;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_taken;
    logic            w_freeze;
    pc_op_t          w_op;

    assign w_op     = pc_op_t'(op);
    assign w_inc    = r_pc + 1'b1;
    assign w_tgt    = Target[PC_W-1:0];
    assign w_rel    = r_pc + PC_W'($signed(Offset));
    assign w_taken  = cond_taken(w_op, ALU_zero);
    assign done     = (r_pc == PC_W'(HALT_ADDR));
    assign w_freeze = done || halt_req;
    assign PC       = r_pc;

    generate
        if (TGT_W > PC_W) begin : g_tgt_hi
            logic w_unused_tgt_hi;
            assign w_unused_tgt_hi = ^Target[TGT_W-1:PC_W];
        end
    endgenerate

`ifdef PC_RAS_EN
    logic                           w_push;
    logic                           w_pop;
    logic                           w_set_ovf;
    logic                           w_set_unf;
    logic                           w_ras_full;
    logic                           w_ras_empty;
    logic [PC_W-1:0]                w_ras_top;
    logic [$clog2(STACK_D+1)-1:0]   w_ras_depth;
    logic                           r_ovf;
    logic                           r_unf;

    pc_ras #(
        .DEPTH (STACK_D),
        .W     (PC_W)
    ) u_ras (
        .clk     (CLK),
        .rst_n   (init_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_inc),
        .o_top   (w_ras_top),
        .o_depth (w_ras_depth),
        .o_full  (w_ras_full),
        .o_empty (w_ras_empty)
    );

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_unf) r_unf <= 1'b1;
        end
    end

    assign ras_depth = w_ras_depth;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;
`else
    assign ras_depth = '0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

    always_comb begin
        w_pc_nxt = r_pc;
`ifdef PC_RAS_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
`endif
        if (!w_freeze) begin
            case (w_op)
                NEXT:       w_pc_nxt = w_inc;
                JMP:        w_pc_nxt = w_tgt;
                BEQZ, BNEZ: w_pc_nxt = w_taken ? w_tgt : w_inc;
                BREL:       w_pc_nxt = w_taken ? w_rel : w_inc;
                CALL: begin
                    // A full stack still takes the jump; the return address is lost.
                    w_pc_nxt = w_tgt;
`ifdef PC_RAS_EN
                    if (w_ras_full) w_set_ovf = 1'b1;
                    else            w_push    = 1'b1;
`endif
                end
                RET: begin
`ifdef PC_RAS_EN
                    if (w_ras_empty) begin
                        w_set_unf = 1'b1;
                        w_pc_nxt  = w_inc;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_ras_top;
                    end
`else
                    w_pc_nxt = w_inc;
`endif
                end
                HOLD:    w_pc_nxt = r_pc;
                default: w_pc_nxt = r_pc;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            r_pc <= PC_W'(START_ADDR);
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a behavioural model predicts each cycle, a scoreboard queue
// holds predictions until the DUT outputs are sampled one clock later.
module tb_pc_unit;
    import pc_pkg::*;

    typedef struct packed {
        logic [9:0] pc;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
        logic       done;
    } exp_t;

    logic        CLK;
    logic        init_n;
    logic        halt_req;
    logic [2:0]  op;
    logic        ALU_zero;
    logic [15:0] Target;
    logic [7:0]  Offset;
    logic [9:0]  PC;
    logic        done;
    logic [2:0]  ras_depth;
    logic        ras_ovf;
    logic        ras_unf;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    int   m_pc;
    int   m_stack[$];
    logic m_ovf;
    logic m_unf;

    pc_unit #(
        .PC_W       (10),
        .TGT_W      (16),
        .OFF_W      (8),
        .STACK_D    (4),
        .START_ADDR (0),
        .HALT_ADDR  (63)
    ) dut (
        .CLK       (CLK),
        .init_n    (init_n),
        .halt_req  (halt_req),
        .op        (op),
        .ALU_zero  (ALU_zero),
        .Target    (Target),
        .Offset    (Offset),
        .PC        (PC),
        .done      (done),
        .ras_depth (ras_depth),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic push_expect();
        exp_t e;
        e.pc    = 10'(m_pc);
        e.depth = 3'(m_stack.size());
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.done  = (m_pc == 63);
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: observed empty scoreboard expected one entry", tag);
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (PC === e.pc) else begin
            miscompares++;
            $error("FAIL %s.pc: observed %0d expected %0d", tag, PC, e.pc);
        end
        vectors++;
        assert (ras_depth === e.depth) else begin
            miscompares++;
            $error("FAIL %s.depth: observed %0d expected %0d", tag, ras_depth, e.depth);
        end
        vectors++;
        assert (ras_ovf === e.ovf) else begin
            miscompares++;
            $error("FAIL %s.ovf: observed %b expected %b", tag, ras_ovf, e.ovf);
        end
        vectors++;
        assert (ras_unf === e.unf) else begin
            miscompares++;
            $error("FAIL %s.unf: observed %b expected %b", tag, ras_unf, e.unf);
        end
        vectors++;
        assert (done === e.done) else begin
            miscompares++;
            $error("FAIL %s.done: observed %b expected %b", tag, done, e.done);
        end
    endtask

    // Drive one op, predict its effect, then sample just after the edge.
    task automatic step(input string tag, input pc_op_t o, input logic z,
                        input logic [15:0] t, input logic [7:0] f, input logic h);
        int inc;
        int tgt;
        op       = o;
        ALU_zero = z;
        Target   = t;
        Offset   = f;
        halt_req = h;
        inc = (m_pc + 1) % 1024;
        tgt = int'(t) % 1024;
        if (m_pc != 63 && !h) begin
            case (o)
                NEXT: m_pc = inc;
                JMP:  m_pc = tgt;
                BEQZ: m_pc = z ? tgt : inc;
                BNEZ: m_pc = !z ? tgt : inc;
                BREL: m_pc = z ? (m_pc + int'($signed(f)) + 1024) % 1024 : inc;
                CALL: begin
`ifdef PC_RAS_EN
                    if (m_stack.size() == 4) m_ovf = 1'b1;
                    else                     m_stack.push_back(inc);
`endif
                    m_pc = tgt;
                end
                RET: begin
`ifdef PC_RAS_EN
                    if (m_stack.size() == 0) begin
                        m_unf = 1'b1;
                        m_pc  = inc;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
`else
                    m_pc = inc;
`endif
                end
                default: m_pc = m_pc;
            endcase
        end
        push_expect();
        @(posedge CLK);
        #1;
        compare(tag);
    endtask

    initial begin
        init_n   = 1'b0;
        halt_req = 1'b0;
        op       = 3'(NEXT);
        ALU_zero = 1'b0;
        Target   = '0;
        Offset   = '0;
        model_reset();
        #2;
        push_expect();
        compare("reset");
        @(negedge CLK);
        init_n = 1'b1;

        step("next1", NEXT, 1'b0, 16'h0000, 8'h00, 1'b0);
        step("next2", NEXT, 1'b0, 16'h0000, 8'h00, 1'b0);
        step("next3", NEXT, 1'b0, 16'h0000, 8'h00, 1'b0);

        step("beqz_taken",  BEQZ, 1'b1, 16'h0128, 8'h00, 1'b0);
        step("beqz_not",    BEQZ, 1'b0, 16'h0300, 8'h00, 1'b0);
        step("bnez_not",    BNEZ, 1'b1, 16'h0300, 8'h00, 1'b0);
        step("bnez_taken",  BNEZ, 1'b0, 16'h0200, 8'h00, 1'b0);
        step("jmp_hibits",  JMP,  1'b0, 16'hFC01, 8'h00, 1'b0);
        step("brel_neg3",   BREL, 1'b1, 16'h0000, 8'hFD, 1'b0);
        step("next_1023",   NEXT, 1'b0, 16'h0000, 8'h00, 1'b0);
        step("inc_wrap",    NEXT, 1'b0, 16'h0000, 8'h00, 1'b0);
        step("brel_not",    BREL, 1'b0, 16'h0000, 8'h05, 1'b0);
        step("brel_pos5",   BREL, 1'b1, 16'h0000, 8'h05, 1'b0);
        step("brel_m128",   BREL, 1'b1, 16'h0000, 8'h80, 1'b0);
        step("hold",        HOLD, 1'b1, 16'h0011, 8'h01, 1'b0);

        step("jmp5",        JMP,  1'b0, 16'd5,   8'h00, 1'b0);
        step("call40",      CALL, 1'b0, 16'd40,  8'h00, 1'b0);
        step("ret6",        RET,  1'b0, 16'd0,   8'h00, 1'b0);
        step("call_n1",     CALL, 1'b0, 16'd100, 8'h00, 1'b0);
        step("call_n2",     CALL, 1'b0, 16'd110, 8'h00, 1'b0);
        step("call_n3",     CALL, 1'b0, 16'd120, 8'h00, 1'b0);
        step("call_n4",     CALL, 1'b0, 16'd130, 8'h00, 1'b0);
        step("call_ovf",    CALL, 1'b0, 16'd140, 8'h00, 1'b0);
        step("ret_n4",      RET,  1'b0, 16'd0,   8'h00, 1'b0);
        step("ret_n3",      RET,  1'b0, 16'd0,   8'h00, 1'b0);
        step("ret_n2",      RET,  1'b0, 16'd0,   8'h00, 1'b0);
        step("ret_n1",      RET,  1'b0, 16'd0,   8'h00, 1'b0);

        step("jmp9",        JMP,  1'b0, 16'd9,   8'h00, 1'b0);
        step("ret_unf",     RET,  1'b0, 16'd0,   8'h00, 1'b0);
        step("unf_sticky",  NEXT, 1'b0, 16'd0,   8'h00, 1'b0);

        step("halt_jmp",    JMP,  1'b0, 16'd300, 8'h00, 1'b1);
        step("call50",      CALL, 1'b0, 16'd50,  8'h00, 1'b0);
        step("halt_call",   CALL, 1'b0, 16'd70,  8'h00, 1'b1);
        step("halt_ret",    RET,  1'b0, 16'd0,   8'h00, 1'b1);
        step("call17",      CALL, 1'b0, 16'd17,  8'h00, 1'b0);

        // Asynchronous reset away from any clock edge.
        init_n = 1'b0;
        model_reset();
        push_expect();
        #1;
        compare("async_reset");
        @(negedge CLK);
        init_n = 1'b1;

        step("jmp60",       JMP,  1'b0, 16'd60,  8'h00, 1'b0);
        step("next61",      NEXT, 1'b0, 16'd0,   8'h00, 1'b0);
        step("next62",      NEXT, 1'b0, 16'd0,   8'h00, 1'b0);
        step("reach_halt",  NEXT, 1'b0, 16'd0,   8'h00, 1'b0);
        step("done_jmp",    JMP,  1'b0, 16'd5,   8'h00, 1'b0);
        step("done_call",   CALL, 1'b0, 16'd40,  8'h00, 1'b0);
        step("done_ret",    RET,  1'b0, 16'd0,   8'h00, 1'b0);
        step("done_haltrq", BEQZ, 1'b1, 16'd7,   8'h00, 1'b1);

        @(negedge CLK);
        init_n = 1'b0;
        model_reset();
        push_expect();
        #1;
        compare("reset_after_done");
        @(negedge CLK);
        init_n = 1'b1;
        step("restart",     NEXT, 1'b0, 16'd0,   8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
